// File: rtl/upper_imm_unit_if.sv
// rtl/upper_imm_unit_if.sv - request/response handshake bundle for upper_imm_unit
// master = decode/writeback side driving requests and consuming results, slave = the unit.
interface upper_imm_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [19:0]      in_imm20;
  logic [XLEN-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;
  logic             in_compressed;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_imm20, in_pc, in_tag, in_compressed, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_imm20, in_pc, in_tag, in_compressed, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/upper_imm_unit.sv
// rtl/upper_imm_unit.sv - buffered LUI/AUIPC/LINK result former with output FIFO
// Optional macro UPPER_IMM_COMPRESSED_EN: LINK adds 2 instead of 4 for compressed instructions.
module upper_imm_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_flush,
  upper_imm_unit_if.slave   io
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [31:0]      w_uimm32;
  logic [XLEN-1:0]  w_uimm;
  logic [XLEN-1:0]  w_link_inc;
  logic [XLEN-1:0]  w_result;
  logic             w_err;
  entry_t           w_new_entry;
  entry_t           w_head;

  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_push;
  logic             w_pop;

  // The size cast of a signed 32-bit value sign-extends bit 31 up to XLEN.
  assign w_uimm32 = {io.in_imm20, 12'b0};
  assign w_uimm   = XLEN'($signed(w_uimm32));

`ifdef UPPER_IMM_COMPRESSED_EN
  assign w_link_inc = io.in_compressed ? XLEN'(2) : XLEN'(4);
`else
  assign w_link_inc = XLEN'(4);
`endif

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (io.in_mode)
      2'b00:   w_result = w_uimm;
      2'b01:   w_result = w_uimm + io.in_pc;
      2'b10:   w_result = io.in_pc + w_link_inc;
      default: w_err    = 1'b1;
    endcase
  end

  assign w_new_entry = '{result: w_result, tag: io.in_tag, err: w_err};

  assign io.in_ready  = (r_state != S_FULL);
  assign io.out_valid = (r_state != S_EMPTY);

  assign w_push = io.in_valid && io.in_ready;
  assign w_pop  = io.out_valid && io.out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
    if (w_count_nxt == '0) begin
      w_state_nxt = S_EMPTY;
    end else if (w_count_nxt == DEPTH_C) begin
      w_state_nxt = S_FULL;
    end else begin
      w_state_nxt = S_PARTIAL;
    end
  end

  // Storage is deliberately left out of reset; out_valid gating hides stale contents.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= w_new_entry;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_EMPTY;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_EMPTY;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign io.out_result = io.out_valid ? w_head.result : '0;
  assign io.out_tag    = io.out_valid ? w_head.tag    : '0;
  assign io.out_err    = io.out_valid ? w_head.err    : 1'b0;
endmodule
